// File: rtl/bus_dma_engine.sv
// bus_dma_engine
// Single-channel word-copy DMA master. It requests the shared bus with a
// req/gnt handshake, then copies LEN 32-bit words from SRC to DST through the
// shared synchronous SRAM port. Each word takes one read, one capture and one
// write cycle.
//
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   cfg_en_i/we_i       register access strobe / write enable
//   cfg_addr_i          0 SRC, 1 DST, 2 LEN, 3 CTRL (write) / STATUS (read)
//   cfg_wdata_i         register write data
//   cfg_rdata_o         combinational read data for cfg_addr_i
//   irq_o               level interrupt = done & irq_en
//   req_dma_o/gnt_dma_i bus request to / grant from the arbiter
//   dma_en_o/we_o       bus access valid / write
//   dma_addr_o          word-aligned byte address
//   dma_wdata_o         write data
//   dma_rdata_i         read data, valid the cycle after a read access
module bus_dma_engine #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cfg_en_i,
  input  logic             cfg_we_i,
  input  logic [1:0]       cfg_addr_i,
  input  logic [31:0]      cfg_wdata_i,
  output logic [31:0]      cfg_rdata_o,
  output logic             irq_o,
  output logic             req_dma_o,
  input  logic             gnt_dma_i,
  output logic             dma_en_o,
  output logic             dma_we_o,
  output logic [31:0]      dma_addr_o,
  output logic [31:0]      dma_wdata_o,
  input  logic [31:0]      dma_rdata_i
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      data_q, data_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;

  logic busy;
  logic cfg_wr;

  assign busy   = (state_q != S_IDLE);
  assign cfg_wr = cfg_en_i & cfg_we_i;

  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    data_d   = data_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;

    // Register writes. Transfer parameters are frozen while busy.
    if (cfg_wr) begin
      case (cfg_addr_i)
        2'd0: if (!busy) src_d = {cfg_wdata_i[31:2], 2'b00};
        2'd1: if (!busy) dst_d = {cfg_wdata_i[31:2], 2'b00};
        2'd2: if (!busy) len_d = cfg_wdata_i[LEN_W-1:0];
        default: begin
          irq_en_d = cfg_wdata_i[2];
          if (cfg_wdata_i[1]) done_d = 1'b0;
          if (cfg_wdata_i[0] && !busy) begin
            if (len_q == '0) begin
              done_d = 1'b1;
            end else begin
              done_d  = 1'b0;
              state_d = S_REQ;
            end
          end
        end
      endcase
    end

    // Any grant loss inside a word restarts that word from RD; counters only
    // advance on a completed write, so the aborted word leaves no trace.
    case (state_q)
      S_REQ: if (gnt_dma_i) state_d = S_RD;
      S_RD:  state_d = gnt_dma_i ? S_CAP : S_REQ;
      S_CAP: begin
        if (gnt_dma_i) begin
          data_d  = dma_rdata_i;
          state_d = S_WR;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WR: begin
        if (gnt_dma_i) begin
          src_d = src_q + 32'd4;
          dst_d = dst_q + 32'd4;
          len_d = len_q - LEN_W'(1);
          // Placed after the register-write decode so a same-cycle
          // DONE_CLR loses against done being set.
          if (len_q == LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RD;
          end
        end else begin
          state_d = S_REQ;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      data_q   <= data_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
    end
  end

  // Bus outputs decode the state register; the grant gate lets an access be
  // withdrawn in the same cycle the arbiter takes the bus away.
  assign req_dma_o   = busy;
  assign dma_en_o    = ((state_q == S_RD) || (state_q == S_WR)) && gnt_dma_i;
  assign dma_we_o    = (state_q == S_WR);
  assign dma_addr_o  = (state_q == S_RD) ? src_q :
                       (state_q == S_WR) ? dst_q : 32'd0;
  assign dma_wdata_o = (state_q == S_WR) ? data_q : 32'd0;
  assign irq_o       = done_q & irq_en_q;

  always_comb begin
    case (cfg_addr_i)
      2'd0:    cfg_rdata_o = src_q;
      2'd1:    cfg_rdata_o = dst_q;
      2'd2:    cfg_rdata_o = 32'(len_q);
      default: cfg_rdata_o = {29'd0, irq_en_q, done_q, busy};
    endcase
  end

endmodule

// File: tb/tb_bus_dma_engine.sv
// Testbench for bus_dma_engine: a memory model and a combinational arbiter
// surround the DMA. Expected bus writes are queued when a copy is started and
// popped when the DMA writes.
module tb_bus_dma_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_en = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_addr = 2'd0;
  logic [31:0] cfg_wdata = 32'd0;
  logic [31:0] cfg_rdata;
  logic        irq;
  logic        req_dma;
  logic        gnt_dma;
  logic        dma_en;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata = 32'd0;

  logic spi_hold   = 1'b0;
  logic force_drop = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cnt  = 0;
  int acc_cnt  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [int unsigned];

  always #5 clk = ~clk;

  // Arbiter: grants the DMA whenever it asks and SPI is not holding the bus.
  assign gnt_dma = req_dma && !spi_hold && !force_drop;

  bus_dma_engine #(.LEN_W(16)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_en_i    (cfg_en),
    .cfg_we_i    (cfg_we),
    .cfg_addr_i  (cfg_addr),
    .cfg_wdata_i (cfg_wdata),
    .cfg_rdata_o (cfg_rdata),
    .irq_o       (irq),
    .req_dma_o   (req_dma),
    .gnt_dma_i   (gnt_dma),
    .dma_en_o    (dma_en),
    .dma_we_o    (dma_we),
    .dma_addr_o  (dma_addr),
    .dma_wdata_o (dma_wdata),
    .dma_rdata_i (dma_rdata)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Synchronous SRAM: read data appears the cycle after the read access.
  always @(posedge clk) begin
    if (dma_en) begin
      if (dma_we) mem[dma_addr] = dma_wdata;
      else        dma_rdata <= mem_rd(dma_addr);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Monitor: counts request cycles and bus accesses, scores each bus write.
  always begin
    @(negedge clk);
    #2;
    if (req_dma) req_cnt++;
    if (dma_en) acc_cnt++;
    if (dma_en && dma_we) begin
      check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("wr_addr", dma_addr, e.a);
        check_eq("wr_data", dma_wdata, e.d);
        $display("write addr=0x%08h data=0x%08h", dma_addr, dma_wdata);
      end
    end
  end

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge clk);
    cfg_en = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  // Program a copy, queue its expected writes, then issue START.
  task automatic start_copy(input logic [31:0] src, input logic [31:0] dst,
                            input int len, input logic [31:0] ctrl);
    cfg_write(2'd0, src);
    cfg_write(2'd1, dst);
    cfg_write(2'd2, 32'(len));
    for (int i = 0; i < len; i++) begin
      exp_t e;
      e.a = dst + 32'(4 * i);
      e.d = mem_rd(src + 32'(4 * i));
      exp_q.push_back(e);
    end
    req_cnt = 0;
    cfg_write(2'd3, ctrl);
  endtask

  task automatic wait_done(input int budget);
    logic [31:0] st;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      cfg_read(2'd3, st);
      if (st[1]) seen = 1'b1;
    end
    check_eq("done_seen", 32'(seen), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int acc0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    check_eq("rst_req", 32'(req_dma), 32'd0);
    check_eq("rst_en", 32'(dma_en), 32'd0);
    check_eq("rst_we", 32'(dma_we), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_addr", dma_addr, 32'd0);
    check_eq("rst_wdata", dma_wdata, 32'd0);
    for (int a = 0; a < 4; a++) begin
      cfg_read(2'(a), rd);
      check_eq("rst_reg", rd, 32'd0);
    end
    rst_n = 1'b1;

    // ---------------- basic copy ----------------
    start_copy(32'h100, 32'h200, 4, 32'h5);
    #1 check_eq("req_t1", 32'(req_dma), 32'd1);
    wait_done(100);
    check_eq("req_cycles", 32'(req_cnt), 32'd13);
    check_eq("irq_set", 32'(irq), 32'd1);
    check_eq("req_drop", 32'(req_dma), 32'd0);
    cfg_read(2'd0, rd); check_eq("src_live", rd, 32'h110);
    cfg_read(2'd1, rd); check_eq("dst_live", rd, 32'h210);
    cfg_read(2'd2, rd); check_eq("len_live", rd, 32'd0);
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    cfg_write(2'd3, 32'h6);
    #1 check_eq("irq_clr", 32'(irq), 32'd0);
    cfg_read(2'd3, rd); check_eq("status_clr", rd, 32'h4);
    for (int i = 0; i < 4; i++)
      check_eq("mem_copy", mem_rd(32'h200 + 32'(4 * i)), 32'h100 + 32'(4 * i) ^ 32'hC0DE_0000);

    // ---------------- LEN = 0 ----------------
    cfg_write(2'd2, 32'd0);
    acc0 = acc_cnt;
    req_cnt = 0;
    cfg_write(2'd3, 32'h1);
    cfg_read(2'd3, rd); check_eq("len0_done", rd, 32'h2);
    repeat (3) @(negedge clk);
    #3;
    check_eq("len0_req", 32'(req_cnt), 32'd0);
    check_eq("len0_acc", 32'(acc_cnt - acc0), 32'd0);

    // ---------------- contention ----------------
    spi_hold = 1'b1;
    start_copy(32'h300, 32'h400, 3, 32'h1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      check_eq("hold_req", 32'(req_dma), 32'd1);
      check_eq("hold_en", 32'(dma_en), 32'd0);
    end
    spi_hold = 1'b0;
    wait_done(100);
    check_eq("cont_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- busy protection ----------------
    start_copy(32'h500, 32'h600, 4, 32'h3);
    cfg_read(2'd3, rd); check_eq("busy_done_clr", rd, 32'h1);
    cfg_write(2'd0, 32'hDEAD0000);
    cfg_write(2'd3, 32'h1);
    cfg_read(2'd3, rd); check_eq("busy_status", 32'(rd[0]), 32'd1);
    wait_done(100);
    cfg_read(2'd0, rd); check_eq("busy_src", rd, 32'h510);
    check_eq("busy_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- wrap and grant loss ----------------
    start_copy(32'hFFFFFFFC, 32'h700, 2, 32'h3);
    @(negedge clk); #1;                       // RD word 1
    check_eq("w_rd1_en", 32'(dma_en), 32'd1);
    check_eq("w_rd1_addr", dma_addr, 32'hFFFFFFFC);
    @(negedge clk);                           // CAP word 1, grant dropped
    force_drop = 1'b1;
    #1 check_eq("w_cap_en", 32'(dma_en), 32'd0);
    cfg_read(2'd2, rd); check_eq("w_len_cap", rd, 32'd2);
    @(negedge clk);                           // back in REQ
    force_drop = 1'b0;
    #1 check_eq("w_req", 32'(req_dma), 32'd1);
    check_eq("w_req_en", 32'(dma_en), 32'd0);
    @(negedge clk); #1;                       // word 1 re-read
    check_eq("w_reread_en", 32'(dma_en), 32'd1);
    check_eq("w_reread_addr", dma_addr, 32'hFFFFFFFC);
    cfg_read(2'd2, rd); check_eq("w_len_rd", rd, 32'd2);
    repeat (2) @(negedge clk);                // CAP, WR
    @(negedge clk); #1;                       // RD word 2 after wrap
    check_eq("w_rd2_addr", dma_addr, 32'h0);
    cfg_read(2'd2, rd); check_eq("w_len_rd2", rd, 32'd1);
    wait_done(100);
    cfg_read(2'd0, rd); check_eq("w_src_wrap", rd, 32'h4);
    check_eq("w_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- reset mid-transfer ----------------
    start_copy(32'h800, 32'h900, 4, 32'h3);
    repeat (6) @(negedge clk);                // WR of word 2
    #1;
    check_eq("r_wr_we", 32'(dma_we), 32'd1);
    check_eq("r_wr_addr", dma_addr, 32'h904);
    rst_n = 1'b0;
    #1;
    check_eq("r_req", 32'(req_dma), 32'd0);
    check_eq("r_en", 32'(dma_en), 32'd0);
    cfg_read(2'd3, rd); check_eq("r_status", rd, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    start_copy(32'hA00, 32'hB00, 2, 32'h1);
    wait_done(100);
    check_eq("r_drained", 32'(exp_q.size()), 32'd0);
    cfg_read(2'd1, rd); check_eq("r_dst", rd, 32'hB08);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
